serial_add_sequencer: RTL
=========================

# serial_add_sequencer

Bit-serial addition controller that wraps a single external 1-bit full adder. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then feeds one bit pair per clock, LSB first, into the full adder's a/b/cin inputs. It registers the returned sum/cout each cycle and presents the WIDTH-bit result plus final carry on an output valid/ready handshake. It sits directly around the full adder: upstream as its operand source, downstream as its result consumer.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- One clock; reset is synchronous and active-high.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand set is presented.
- in_ready  output  1  block can accept operands.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- carry_in  input  1  initial carry.
- fa_a  output  1  to full adder input a.
- fa_b  output  1  to full adder input b.
- fa_cin  output  1  to full adder carry input.
- fa_sum  input  1  from full adder sum.
- fa_cout  input  1  from full adder carry output.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum bits; bit 0 is the first bit computed.
- carry_out  output  1  final carry.

## Operation
- States:
  - IDLE: in_ready=1; fa_a, fa_b and fa_cin are all 0.
  - BUSY: processes one bit per cycle.
  - DONE: out_valid=1.
- IDLE -> BUSY on in_valid & in_ready:
  - Load shift_a=op_a, shift_b=op_b, carry_reg=carry_in, count=0.
  - Clear the result shift register.
- BUSY, combinational outputs: fa_a=shift_a[0], fa_b=shift_b[0], fa_cin=carry_reg.
- BUSY, each edge:
  - Shift result right, inserting fa_sum at bit WIDTH-1.
  - carry_reg <= fa_cout.
  - Shift shift_a and shift_b right, filling with 0.
  - count <= count+1.
- BUSY -> DONE on the edge where count==WIDTH-1. That edge also captures the last bit. carry_out then equals carry_reg.
- DONE: result and carry_out are held stable. fa_a, fa_b and fa_cin are 0. DONE -> IDLE on out_ready.
- in_ready=0 in BUSY and DONE. in_valid in those states is ignored: no queuing and no error.
- Counter width is $clog2(WIDTH). Arithmetic is modulo 2^WIDTH, with the overflow bit in carry_out.
- result and carry_out keep their last values after the DONE->IDLE transition. They change only when the next operation starts shifting.
- rst, whenever asserted:
  - Next edge: state=IDLE, count=0, result=0, carry_out=0, carry_reg=0, shift registers=0.
  - An in-flight operation is discarded with no output.
  - in_ready is forced to 0 while rst is high.
- Reset values after the reset edge: in_ready=1 (once rst is low), out_valid=0, result=0, carry_out=0, fa_a=0, fa_b=0, fa_cin=0.

## Timing
- Accept edge E0: in_valid & in_ready sampled high. State becomes BUSY after E0.
- Bit i (i = 0..WIDTH-1) is driven to the full adder during the cycle after E(i). It is captured at E(i+1).
- out_valid rises after edge E(WIDTH), i.e. WIDTH cycles after the accept edge.
- With out_ready held high:
  - out_valid lasts exactly 1 cycle.
  - IDLE follows E(WIDTH+1).
  - The next accept is possible at E(WIDTH+2).
  - Peak throughput is one operation per WIDTH+2 cycles.
- The full adder path is purely combinational: fa_sum/fa_cout must settle within the same cycle as fa_a/fa_b/fa_cin.
- Backpressure: out_valid, result and carry_out stay constant for as long as out_ready is low.

## Test plan
- WIDTH=8; op_a=8'hFF, op_b=8'h01, carry_in=0 -> out_valid 8 cycles after accept; result=8'h00, carry_out=1.
- op_a=8'h5A, op_b=8'h25, carry_in=1 -> result=8'h80, carry_out=0.
- While BUSY, check fa_a/fa_b against op_a/op_b bit i each cycle and fa_cin against the running carry. While IDLE/DONE, fa_a, fa_b and fa_cin are all 0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, result and carry_out stable. Present a new in_valid during BUSY/DONE -> ignored, in_ready=0. Raise out_ready -> IDLE next edge, in_ready=1.
- Assert rst at bit 3 of an operation -> after the edge: IDLE, out_valid=0, result=0, carry_out=0. A following op 8'h10+8'h20 -> result=8'h30, carry_out=0.
- 1000 random back-to-back operations with random out_ready stalls, at WIDTH=8 and WIDTH=2 -> {carry_out,result} == op_a+op_b+carry_in every time, and each accept gets exactly one out_valid.

Source files
------------

// File: rtl/serial_add_sequencer_if.sv
// ============================================================================
// Module      : serial_add_sequencer_if
// Description : Bundle of the operand handshake, full-adder link and result
//               handshake used by serial_add_sequencer.
//               slave  modport : the sequencer itself
//               master modport : the surrounding environment (operand source,
//                                external full adder, result consumer)
// Ports       : in_valid/in_ready/op_a/op_b/carry_in   operand handshake
//               fa_a/fa_b/fa_cin/fa_sum/fa_cout        full adder link
//               out_valid/out_ready/result/carry_out   result handshake
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport slave (
    input  in_valid, op_a, op_b, carry_in, fa_sum, fa_cout, out_ready,
    output in_ready, fa_a, fa_b, fa_cin, out_valid, result, carry_out
  );

  modport master (
    output in_valid, op_a, op_b, carry_in, fa_sum, fa_cout, out_ready,
    input  in_ready, fa_a, fa_b, fa_cin, out_valid, result, carry_out
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
// Module      : serial_add_sequencer
// Description : Bit-serial adder controller around an external 1-bit full
//               adder. Operands are accepted on a valid/ready handshake, fed
//               LSB first one bit per cycle, and the WIDTH-bit sum plus final
//               carry is offered on an output valid/ready handshake.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - serial_add_sequencer_if.slave (operand handshake,
//                      full adder link, result handshake)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  serial_add_sequencer_if.slave   bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shift_a_q,   shift_a_d;
  logic [WIDTH-1:0] shift_b_q,   shift_b_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_q,     carry_d;
  logic             carry_out_q, carry_out_d;
  logic [CW-1:0]    count_q,     count_d;

  logic             in_ready;
  logic             out_valid;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;

  always_comb begin
    state_d     = state_q;
    shift_a_d   = shift_a_q;
    shift_b_d   = shift_b_q;
    result_d    = result_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    count_d     = count_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    fa_a        = 1'b0;
    fa_b        = 1'b0;
    fa_cin      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Held low during reset so no operand is taken on the reset edge.
        in_ready = ~rst;
        if (bus.in_valid && in_ready) begin
          state_d   = S_BUSY;
          shift_a_d = bus.op_a;
          shift_b_d = bus.op_b;
          carry_d   = bus.carry_in;
          count_d   = '0;
          result_d  = '0;
        end
      end

      S_BUSY: begin
        fa_a      = shift_a_q[0];
        fa_b      = shift_b_q[0];
        fa_cin    = carry_q;
        // Sum bits enter at the top so that after WIDTH shifts the first
        // computed bit has arrived at bit 0.
        result_d  = {bus.fa_sum, result_q[WIDTH-1:1]};
        carry_d   = bus.fa_cout;
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        count_d   = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = S_DONE;
          // Separate from carry_q so the final carry survives the next
          // accept, which reloads carry_q with the new carry_in.
          carry_out_d = bus.fa_cout;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_a_q   <= '0;
      shift_b_q   <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_a_q   <= shift_a_d;
      shift_b_q   <= shift_b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.fa_a      = fa_a;
  assign bus.fa_b      = fa_b;
  assign bus.fa_cin    = fa_cin;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;

endmodule

`default_nettype wire
